sccb_responder: RTL
===================

Name: sccb_responder

Overview:
- SCCB/I2C-style target model with the camera-side register file, placed at the far end of the `scl`/`sda` bus from our SCCB configuration master.
- Oversamples `scl`/`sda` on `sys_clk`, decodes 3-phase writes and 2-phase-write + 2-phase-read transactions, and keeps a 256x8 register space.
- Exposes register write events and a debug read port, so the configuration sequence can be checked in RTL simulation and on the board.

Parameters:
- DEVICE_ID, 8'h42: 8-bit write address. The read address is DEVICE_ID | 1.
- FILT_LEN, 4: number of consecutive equal `sys_clk` samples required before a line level is accepted.
- ACK_EN, 1: 1 = drive SDA low in write-phase 9th bits; 0 = leave the 9th bit undriven (don't-care).
- COM7_ADDR, 8'h12: soft-reset register address. Bit 7 of this register is the soft-reset request.

Ports:
- sys_clk  input  1  system clock (100 MHz).
- rst  input  1  reset, synchronous, active-high.
- scl  input  1  SCCB clock from the master.
- sda  inout  1  SCCB data, open-drain. The block drives only 1'b0 or z.
- wr_stb  output  1  one-cycle pulse per register write.
- wr_addr  output  8  address of the write.
- wr_data  output  8  data of the write.
- soft_rst  output  1  one-cycle pulse when COM7_ADDR is written with bit 7 = 1.
- busy  output  1  high from START until STOP or return to IDLE.
- dbg_addr  input  8  debug read address.
- dbg_data  output  8  combinational `regs[dbg_addr]`.

Behaviour:
- Reset: all outputs 0, SDA released (z), state IDLE, `sub_addr` = 8'h00, bit counter 0. Register file contents are not cleared by reset.
- Line conditioning, per line:
  - 2-flop synchroniser, then filter: the level is accepted after FILT_LEN equal samples.
  - Rise/fall strobes are derived from the filtered levels.
  - Latency from pin to strobe: 2 + FILT_LEN cycles.
- Bus conditions:
  - START: filtered SDA falls while filtered SCL is high.
  - STOP: filtered SDA rises while filtered SCL is high.
  - Data is sampled on the SCL rise strobe. The block changes its SDA drive only on the SCL fall strobe.
- States: IDLE, DEV_ID, DEV_ACK, SUB_ADDR, SUB_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- START from any state (including a repeated START): go to DEV_ID, clear the bit counter, release SDA, set busy.
- STOP from any state: go to IDLE, release SDA, clear busy. If STOP arrives mid-byte, the partial byte is discarded with no write.
- DEV_ID (8 bits, MSB first):
  - Byte == DEVICE_ID → DEV_ACK, then SUB_ADDR.
  - Byte == DEVICE_ID|1 → DEV_ACK, then RD_DATA.
  - Any other byte → WAIT_STOP with SDA never driven.
- ACK slots (DEV_ACK, SUB_ACK, WR_ACK):
  - With ACK_EN = 1, SDA is driven low from the SCL fall after bit 8 until the next SCL fall.
  - With ACK_EN = 0, SDA is not driven.
- SUB_ADDR → SUB_ACK → WR_DATA: the received byte is loaded into `sub_addr`.
- WR_DATA complete (8th SCL rise):
  - Writes `regs[sub_addr]` and pulses `wr_stb` with `wr_addr`/`wr_data`. The pulse is on the cycle after the strobe.
  - Moves to WR_ACK, then back to WR_DATA with `sub_addr` + 1 (8-bit wrap: 8'hFF → 8'h00).
- soft_rst: pulses on the same cycle as `wr_stb` when `wr_addr` == COM7_ADDR and `wr_data[7]` = 1.
- RD_DATA:
  - Loads `regs[sub_addr]` into the shift register on entry.
  - Drives the MSB on the SCL fall ending DEV_ACK, then the next bit on each subsequent SCL fall.
  - A '1' bit means release (z); a '0' bit means drive low.
  - After 8 bits, releases SDA and enters RD_ACK.
- RD_ACK: samples the master's 9th bit on the SCL rise.
  - 1 (NA) → WAIT_STOP.
  - 0 → `sub_addr` + 1 (wrap), back to RD_DATA.
- `sub_addr` persists across transactions, so a 2-phase write sets the address for the following read.
- Simultaneous strobes: START/STOP detection takes priority over data sampling in the same cycle.
- Reset asserted mid-transaction: on the next `sys_clk` edge the block returns to IDLE, releases SDA and drops busy. A partial write is discarded.

Decomposition:
- Package `sccb_pkg`:
  - state enum;
  - DEVICE_ID default;
  - COM7_ADDR;
  - soft-reset bit index (7);
  - read/write direction bit.
- Sub-module `sccb_line_filter`: synchroniser + FILT_LEN filter + rise/fall strobes. Instantiated once for SCL and once for SDA.

Test Plan:
- Write 42/12/80 then STOP → `wr_stb` ×1 with addr 8'h12, data 8'h80; `soft_rst` ×1; SDA low in all three ACK slots; busy drops after STOP.
- Write 42/3A/04, STOP; START, 42/3A, STOP; START, 43, master NA, STOP → SDA carries 0000_0100; SDA released after bit 8.
- ID 8'h60 followed by two bytes → SDA never driven, no `wr_stb`, IDLE after STOP.
- Write 42/FF/11/22 → writes regs[FF]=11 then regs[00]=22; `dbg_addr`=00 reads 22.
- Repeated START after 3 bits of WR_DATA, then 42/05/A5 → single write regs[05]=A5, no stray write. SCL glitch of FILT_LEN-1 cycles → no bit sampled.
- `rst` pulsed during the 4th bit of RD_DATA → SDA z on the following cycle, state IDLE, busy 0, outputs 0.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder model.
package sccb_pkg;
  typedef enum logic [3:0] {
    IDLE, DEV_ID, DEV_ACK, SUB_ADDR, SUB_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  localparam logic [7:0] DEVICE_ID_DEF = 8'h42;
  localparam logic [7:0] COM7_ADDR_DEF = 8'h12;
  localparam int         SRST_BIT      = 7;
  localparam logic       DIR_RD        = 1'b1;
endpackage

// File: rtl/sccb_line_filter.sv
// Two-flop synchroniser plus FILT_LEN-sample glitch filter with edge strobes.
module sccb_line_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  // sh[1:0] is the synchroniser; sh[FILT_LEN:1] is the acceptance window
  logic [FILT_LEN:0] sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh    <= '1;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sh   <= {sh[FILT_LEN-1:0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      if ((&sh[FILT_LEN:1]) && !level) begin
        level <= 1'b1;
        rise  <= 1'b1;
      end else if (!(|sh[FILT_LEN:1]) && level) begin
        level <= 1'b0;
        fall  <= 1'b0 | 1'b1;
      end
    end
  end
endmodule

// File: rtl/sccb_responder.sv
// SCCB target with a 256x8 register file, write-event outputs and debug read port.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID = DEVICE_ID_DEF,
  parameter int         FILT_LEN  = 4,
  parameter bit         ACK_EN    = 1'b1,
  parameter logic [7:0] COM7_ADDR = COM7_ADDR_DEF
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       soft_rst,
  output logic       busy,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);
  localparam logic [7:0] RD_ID = {DEVICE_ID[7:1], DIR_RD};

  logic       scl_lvl, scl_rise, scl_fall;
  logic       sda_lvl, sda_rise, sda_fall;
  logic       start, stop;
  state_t     state;
  logic [7:0] sub_addr, shreg;
  logic [3:0] bit_cnt;
  logic       sda_oe;
  logic [7:0] regs [256];
  logic [7:0] byte_in;
  logic       last_bit;

  sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
    .clk(sys_clk), .rst(rst), .din(scl),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
    .clk(sys_clk), .rst(rst), .din(sda),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  assign sda      = sda_oe ? 1'b0 : 1'bz;
  assign start    = sda_fall && scl_lvl;
  assign stop     = sda_rise && scl_lvl;
  assign byte_in  = {shreg[6:0], sda_lvl};
  assign last_bit = (bit_cnt == 4'd7);
  assign dbg_data = regs[dbg_addr];

  // Register file is not reset; it commits the registered write event.
  always_ff @(posedge sys_clk) begin
    if (wr_stb) regs[wr_addr] <= wr_data;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= IDLE;
      sub_addr <= 8'h00;
      shreg    <= 8'h00;
      bit_cnt  <= 4'd0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_stb   <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
      soft_rst <= 1'b0;
    end else begin
      wr_stb   <= 1'b0;
      soft_rst <= 1'b0;
      if (start) begin
        state   <= DEV_ID;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          DEV_ID: begin
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (last_bit)
              state <= (byte_in == DEVICE_ID || byte_in == RD_ID) ? DEV_ACK : WAIT_STOP;
          end
          DEV_ACK: begin
            bit_cnt <= 4'd0;
            if (shreg == RD_ID) begin
              state <= RD_DATA;
              shreg <= regs[sub_addr];
            end else begin
              state <= SUB_ADDR;
            end
          end
          SUB_ADDR: begin
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (last_bit) begin
              sub_addr <= byte_in;
              state    <= SUB_ACK;
            end
          end
          SUB_ACK: begin
            state   <= WR_DATA;
            bit_cnt <= 4'd0;
          end
          WR_DATA: begin
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (last_bit) begin
              wr_stb   <= 1'b1;
              wr_addr  <= sub_addr;
              wr_data  <= byte_in;
              soft_rst <= (sub_addr == COM7_ADDR) && byte_in[SRST_BIT];
              state    <= WR_ACK;
            end
          end
          WR_ACK: begin
            sub_addr <= sub_addr + 8'd1;
            state    <= WR_DATA;
            bit_cnt  <= 4'd0;
          end
          RD_ACK: begin
            bit_cnt <= 4'd0;
            if (sda_lvl) begin
              state <= WAIT_STOP;
            end else begin
              sub_addr <= sub_addr + 8'd1;
              shreg    <= regs[sub_addr + 8'd1];
              state    <= RD_DATA;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          DEV_ACK, SUB_ACK, WR_ACK: sda_oe <= ACK_EN;
          RD_DATA: begin
            // Ninth fall of a read byte hands SDA back for the master's ACK/NA
            if (bit_cnt == 4'd8) begin
              sda_oe <= 1'b0;
              state  <= RD_ACK;
            end else begin
              sda_oe  <= ~shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end
endmodule
